alu_stream_engine: RTL



---
 rtl/alu_stream_engine.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_stream_engine.sv
// Handshaked multi-cycle 256-bit ALU: operands are processed LSB-first, one SLICE per cycle,
// with a carry chain across slices. Optional macro ALU_ZERO_FLAG_EN adds the res_zero output.
module alu_stream_engine #(
  parameter int WIDTH = 256,
  parameter int SLICE = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op0_value,
  input  logic [WIDTH-1:0] op1_value,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic             res_zero
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {MODE_ADD, MODE_SUB, MODE_AND, MODE_XOR} mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic [WIDTH-1:0]  op0_q, op1_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic              last_slice;
  logic [SLICE-1:0]  a_s, b_s, slice_res;
  logic              slice_carry;
`ifdef ALU_ZERO_FLAG_EN
  logic              zero_q;
  assign res_zero = zero_q;
`endif

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign last_slice = (idx_q == IDXW'(NSLICE - 1));

  // One slice of the operation; sub is op0 + ~op1 with the carry chain seeded to 1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    a_s         = op0_q[idx_q*SLICE +: SLICE];
    b_s         = op1_q[idx_q*SLICE +: SLICE];
    slice_res   = '0;
    slice_carry = 1'b0;
    unique case (mode_q)
      MODE_ADD: {slice_carry, slice_res} = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
      MODE_SUB: {slice_carry, slice_res} = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE{1'b0}}, carry_q};
      MODE_AND: slice_res = a_s & b_s;
      MODE_XOR: slice_res = a_s ^ b_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = CALC;
      CALC:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every datapath register is cleared so an aborted request leaves no trace.
    if (!rst_n) begin
      op0_q     <= '0;
      op1_q     <= '0;
      mode_q    <= MODE_ADD;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      alu_out   <= '0;
      carry_out <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          op0_q   <= op0_value;
          op1_q   <= op1_value;
          mode_q  <= mode_t'(mode);
          carry_q <= (mode == 2'd1);
          idx_q   <= '0;
`ifdef ALU_ZERO_FLAG_EN
          zero_q  <= 1'b1;
`endif
        end
        CALC: begin
          alu_out[idx_q*SLICE +: SLICE] <= slice_res;
          carry_q <= slice_carry;
          idx_q   <= last_slice ? '0 : idx_q + 1'b1;
          if (last_slice) carry_out <= slice_carry;
`ifdef ALU_ZERO_FLAG_EN
          zero_q  <= zero_q & (slice_res == '0);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
